serial_xnor_compare: RTL and testbench

- Bit-serial equality checker that sits directly downstream of the XNOR gate stage.
- Consumes one (a, b) bit pair per valid cycle and forms the per-bit XNOR internally (1 = bits agree).
- Accumulates agreement over a frame of WIDTH bits, then reports match count, equality flag and the index of the first disagreeing bit.
- Used to compare two serial words, e.g. a received word against an expected word.

---
 rtl/serial_xnor_compare.sv | 133 +++++++++++++
 tb/tb_serial_xnor_compare.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_xnor_compare.sv
// serial_xnor_compare
// Bit-serial equality checker. Takes one (a, b) bit pair per valid cycle,
// forms the per-bit XNOR (1 = bits agree), and after WIDTH pairs reports
// the number of agreeing pairs, an equality flag and the arrival index of
// the first disagreeing pair. Results hold until the next accepted start
// or clear.
module serial_xnor_compare #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             bit_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic [CNT_W-1:0] match_count,
    output logic [IDX_W-1:0] mismatch_idx
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(WIDTH);

    state_t           state_reg;
    state_t           state_next;
    logic [IDX_W-1:0] bit_cnt_reg;
    logic [CNT_W-1:0] match_count_reg;
    logic [IDX_W-1:0] mismatch_idx_reg;
    logic             recorded_reg;
    logic             equal_reg;

    logic             agree;
    logic             take_bit;
    logic             last_bit;
    logic             accept_start;
    logic [CNT_W-1:0] count_next;

    // Per-pair agreement and the events that drive the datapath.
    assign agree        = ~(a_bit ^ b_bit);
    assign take_bit     = (state_reg == S_COLLECT) && bit_valid;
    assign last_bit     = take_bit && (bit_cnt_reg == LAST_IDX);
    // start is only honoured when no frame is in flight (IDLE or the DONE cycle).
    assign accept_start = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign count_next   = match_count_reg + {{(CNT_W-1){1'b0}}, agree};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; clear overrides everything else.
    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) state_next = S_COLLECT;
                end
                S_COLLECT: begin
                    if (last_bit) state_next = S_DONE;
                end
                S_DONE: begin
                    state_next = start ? S_COLLECT : S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // State-decoded outputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            S_COLLECT: busy = 1'b1;
            S_DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Frame datapath: counter, match tally, first-mismatch capture, equal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg      <= '0;
            match_count_reg  <= '0;
            mismatch_idx_reg <= '0;
            recorded_reg     <= 1'b0;
            equal_reg        <= 1'b0;
        end else if (clear || accept_start) begin
            bit_cnt_reg      <= '0;
            match_count_reg  <= '0;
            mismatch_idx_reg <= '0;
            recorded_reg     <= 1'b0;
            equal_reg        <= 1'b0;
        end else if (take_bit) begin
            match_count_reg <= count_next;
            if (!agree && !recorded_reg) begin
                mismatch_idx_reg <= bit_cnt_reg;
                recorded_reg     <= 1'b1;
            end
            // Counter stops at the last index; the next start clears it.
            if (!last_bit) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
            // Registered on the closing edge so it is valid alongside done.
            if (last_bit) begin
                equal_reg <= (count_next == FULL_COUNT);
            end
        end
    end

    assign equal        = equal_reg;
    assign match_count  = match_count_reg;
    assign mismatch_idx = mismatch_idx_reg;

endmodule

// File: tb/tb_serial_xnor_compare.sv
// Testbench for serial_xnor_compare: directed scenarios plus randomized
// frames checked against a word-level reference model.
module tb_serial_xnor_compare;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             clear;
    logic             bit_valid;
    logic             a_bit;
    logic             b_bit;
    logic             busy;
    logic             done;
    logic             equal;
    logic [CNT_W-1:0] match_count;
    logic [IDX_W-1:0] mismatch_idx;

    int total;
    int bad;
    int cyc;

    serial_xnor_compare #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .IDX_W(IDX_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .clear       (clear),
        .bit_valid   (bit_valid),
        .a_bit       (a_bit),
        .b_bit       (b_bit),
        .busy        (busy),
        .done        (done),
        .equal       (equal),
        .match_count (match_count),
        .mismatch_idx(mismatch_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Word-level reference: agreement count, first differing bit, equality.
    function automatic int ref_count(input logic [7:0] a, input logic [7:0] b);
        return WIDTH - $countones(a ^ b);
    endfunction

    function automatic int ref_idx(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] diff;
        diff = a ^ b;
        for (int i = 0; i < WIDTH; i++) begin
            if (diff[i]) return i;
        end
        return 0;
    endfunction

    // Run one frame starting in the current cycle (LSB first). Optionally
    // stalls before bit stall_pos for stall_len cycles, pulsing start
    // during the stall when start_mid is set. Returns in the DONE cycle.
    task automatic frame(input logic [7:0] a, input logic [7:0] b,
                         input int stall_pos, input int stall_len, input bit start_mid);
        int c0;
        int n;
        c0        = cyc;
        start     = 1'b1;
        bit_valid = 1'b0;
        tick();
        start = 1'b0;
        chk("busy_collect", {31'd0, busy}, 32'd1);
        for (int i = 0; i < WIDTH; i++) begin
            if (i == stall_pos) begin
                for (int s = 0; s < stall_len; s++) begin
                    bit_valid = 1'b0;
                    start     = start_mid;
                    a_bit     = 1'($urandom);
                    b_bit     = 1'($urandom);
                    tick();
                    start = 1'b0;
                    chk("busy_stall", {31'd0, busy}, 32'd1);
                end
            end
            bit_valid = 1'b1;
            a_bit     = a[i];
            b_bit     = b[i];
            tick();
        end
        bit_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("latency", 32'(cyc - c0), 32'(WIDTH + 1 + stall_len));
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("equal", {31'd0, equal}, {31'd0, (a == b)});
        chk("match_count", {28'd0, match_count}, 32'(ref_count(a, b)));
        chk("mismatch_idx", {29'd0, mismatch_idx}, 32'(ref_idx(a, b)));
        $display("frame a=%02h b=%02h stall=%0d@%0d -> eq=%0b cnt=%0d idx=%0d lat=%0d",
                 a, b, stall_len, stall_pos, equal, match_count, mismatch_idx, cyc - c0);
    endtask

    // One idle cycle after DONE: done drops, results hold.
    task automatic idle_hold(input logic [7:0] a, input logic [7:0] b);
        start     = 1'b0;
        bit_valid = 1'b1;
        a_bit     = 1'b0;
        b_bit     = 1'b1;
        tick();
        bit_valid = 1'b0;
        chk("done_once", {31'd0, done}, 32'd0);
        chk("hold_equal", {31'd0, equal}, {31'd0, (a == b)});
        chk("hold_count", {28'd0, match_count}, 32'(ref_count(a, b)));
        chk("hold_idx", {29'd0, mismatch_idx}, 32'(ref_idx(a, b)));
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        total     = 0;
        bad       = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        clear     = 1'b0;
        bit_valid = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        repeat (2) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_equal", {31'd0, equal}, 32'd0);
        chk("rst_count", {28'd0, match_count}, 32'd0);
        chk("rst_idx", {29'd0, mismatch_idx}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Identical words.
        frame(8'hA5, 8'hA5, 99, 0, 1'b0);
        idle_hold(8'hA5, 8'hA5);
        // Two mismatches, then one.
        frame(8'hFF, 8'hF6, 99, 0, 1'b0);
        idle_hold(8'hFF, 8'hF6);
        frame(8'hFF, 8'hF7, 99, 0, 1'b0);
        idle_hold(8'hFF, 8'hF7);
        // Stall of 3 with start pulsed mid-frame.
        frame(8'hA5, 8'hA5, 4, 3, 1'b1);
        idle_hold(8'hA5, 8'hA5);
        // Back-to-back: second start issued in the first DONE cycle.
        frame(8'hA5, 8'hA5, 99, 0, 1'b0);
        frame(8'h00, 8'hFF, 99, 0, 1'b0);
        idle_hold(8'h00, 8'hFF);

        // Abort after 4 bits.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            a_bit     = 1'(i);
            b_bit     = 1'(i);
            tick();
        end
        bit_valid = 1'b0;
        chk("pre_clear_count", {28'd0, match_count}, 32'd4);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_busy", {31'd0, busy}, 32'd0);
        chk("clear_done", {31'd0, done}, 32'd0);
        chk("clear_count", {28'd0, match_count}, 32'd0);
        chk("clear_equal", {31'd0, equal}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            bit_valid = 1'b1;
            tick();
            chk("clear_no_done", {31'd0, done}, 32'd0);
        end
        bit_valid = 1'b0;
        $display("abort after 4 bits -> busy=%0b cnt=%0d", busy, match_count);
        frame(8'h3C, 8'h3C, 99, 0, 1'b0);
        idle_hold(8'h3C, 8'h3C);

        // Asynchronous reset mid-frame.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1;
            a_bit     = 1'b1;
            b_bit     = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        chk("pre_rst_count", {28'd0, match_count}, 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_count", {28'd0, match_count}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bit_valid = 1'b1;
            a_bit     = 1'($urandom);
            b_bit     = 1'($urandom);
            tick();
            chk("arst_no_done", {31'd0, done}, 32'd0);
            chk("arst_no_busy", {31'd0, busy}, 32'd0);
        end
        bit_valid = 1'b0;
        $display("async reset mid-frame -> busy=%0b cnt=%0d", busy, match_count);

        // Randomized frames, mixing stalls, equal words and back-to-back.
        for (int k = 0; k < 24; k++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            frame(ra, rb, $urandom_range(0, WIDTH - 1), $urandom_range(0, 3),
                  1'($urandom));
            if ($urandom_range(0, 1) == 1) idle_hold(ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
